// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit driving a word-wide DMem port with byte enables
module load_store_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);

    state_t      state, state_d;
    logic [1:0]  cnt, cnt_d;
    logic [1:0]  off, off_d;
    logic [2:0]  f3, f3_d;
    logic        is_load, is_load_d;
    logic        req_ready_d, resp_valid_d, resp_err_d, mem_rd_d;
    logic [31:0] resp_rdata_d, mem_addr_d, mem_wdata_d;
    logic [3:0]  mem_we_d;
    logic        req_err;
    logic [31:0] lane;

    always_comb begin
        case (req_funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = req_addr[0];
            3'b010:  req_err = |req_addr[1:0];
            3'b100:  req_err = req_store;
            3'b101:  req_err = req_store | req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    assign lane = mem_rdata >> {off, 3'b000};

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        off_d        = off;
        f3_d         = f3;
        is_load_d    = is_load;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        mem_rd_d     = 1'b0;
        mem_we_d     = 4'b0000;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        case (state)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    req_ready_d = 1'b0;
                    off_d       = req_addr[1:0];
                    f3_d        = req_funct3;
                    is_load_d   = ~req_store;
                    cnt_d       = 2'd0;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d    = ACCESS;
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        if (req_store) begin
                            // Lanes are replicated so the enabled bytes always carry the right data
                            case (req_funct3)
                                3'b000: begin
                                    mem_we_d    = 4'b0001 << req_addr[1:0];
                                    mem_wdata_d = {4{req_wdata[7:0]}};
                                end
                                3'b001: begin
                                    mem_we_d    = 4'b0011 << req_addr[1:0];
                                    mem_wdata_d = {2{req_wdata[15:0]}};
                                end
                                default: begin
                                    mem_we_d    = 4'b1111;
                                    mem_wdata_d = req_wdata;
                                end
                            endcase
                        end else begin
                            mem_rd_d = 1'b1;
                        end
                    end
                end
            end
            ACCESS: begin
                if (!is_load) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else if (cnt == LAST_CNT) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    case (f3)
                        3'b000:  resp_rdata_d = {{24{lane[7]}}, lane[7:0]};
                        3'b001:  resp_rdata_d = {{16{lane[15]}}, lane[15:0]};
                        3'b100:  resp_rdata_d = {24'h0, lane[7:0]};
                        3'b101:  resp_rdata_d = {16'h0, lane[15:0]};
                        default: resp_rdata_d = lane;
                    endcase
                end else begin
                    cnt_d    = cnt + 2'd1;
                    mem_rd_d = 1'b1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            off        <= 2'd0;
            f3         <= 3'd0;
            is_load    <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_we     <= 4'b0000;
            mem_rd     <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            off        <= off_d;
            f3         <= f3_d;
            is_load    <= is_load_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_we     <= mem_we_d;
            mem_rd     <= mem_rd_d;
        end
    end
endmodule
